// File: rtl/wavetable_pkg.sv
// Shared wavetable layout: table geometry, per-wave base addresses and framing constants.
// The oscillator read path imports this too, so the layout lives in one place.
package wavetable_pkg;

  localparam int N_LUT      = 10;
  localparam int LUT_LEN    = 1 << N_LUT;
  localparam int DATA_W     = 24;
  localparam int NUM_BANDS  = 22;
  localparam int NUM_TABLES = 3 * NUM_BANDS + 1;
  localparam int DEPTH      = NUM_TABLES * LUT_LEN;
  localparam int ADDR_W     = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] SQUARE_BASE   = '0;
  localparam logic [ADDR_W-1:0] SAW_BASE      = ADDR_W'(LUT_LEN * NUM_BANDS);
  localparam logic [ADDR_W-1:0] TRIANGLE_BASE = ADDR_W'(2 * LUT_LEN * NUM_BANDS);
  localparam logic [ADDR_W-1:0] SINE_BASE     = ADDR_W'(3 * LUT_LEN * NUM_BANDS);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    WAVE_SQUARE   = 2'd0,
    WAVE_SAW      = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SINE     = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } wl_state_t;

  // Sine has a single table, so its band term is dropped.
  function automatic logic [ADDR_W-1:0] table_base(input wave_t wave, input logic [4:0] band);
    logic [ADDR_W-1:0] band_off;
    band_off = ADDR_W'(band) << N_LUT;
    case (wave)
      WAVE_SQUARE:   table_base = SQUARE_BASE + band_off;
      WAVE_SAW:      table_base = SAW_BASE + band_off;
      WAVE_TRIANGLE: table_base = TRIANGLE_BASE + band_off;
      default:       table_base = SINE_BASE;
    endcase
  endfunction

endpackage

// File: rtl/wavetable_writer_sample_packer.sv
// Packs payload bytes MSB first into 24-bit samples and keeps the running payload checksum.
// sample/sample_valid are combinational on the third byte so the caller can register the write.
module sample_packer
  import wavetable_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic [7:0]        csum
);

  logic [1:0]  byte_cnt;
  logic [15:0] shift;

  assign sample       = {shift, byte_data};
  assign sample_valid = byte_valid && (byte_cnt == 2'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      shift    <= '0;
      csum     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      csum     <= '0;
    end else if (byte_valid) begin
      shift    <= {shift[7:0], byte_data};
      csum     <= csum + byte_data;
      byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/wavetable_writer.sv
// Frame parser that streams host wavetable uploads into the wavetable RAM write port.
// state   | meaning
// IDLE    | hunting for SYNC, all other bytes dropped
// SEL     | next byte picks wave/band; illegal selection pulses err
// DATA    | LUT_LEN samples of 3 bytes, one RAM write per sample
// CSUM    | compare checksum byte, pulse done or err
module wavetable_writer
  import wavetable_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  wl_state_t         state;
  logic [N_LUT-1:0]  idx;
  logic [ADDR_W-1:0] tbase;
  logic              accept;
  logic              sel_legal;
  wave_t             sel_wave;
  logic [4:0]        sel_band;
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic [7:0]        csum;

  assign accept   = s_valid && s_ready;
  assign sel_wave = wave_t'(s_data[7:6]);
  assign sel_band = s_data[4:0];

  always_comb begin
    sel_legal = 1'b0;
    if (sel_wave == WAVE_SINE) sel_legal = (sel_band == 5'd0);
    else                       sel_legal = (sel_band < 5'(NUM_BANDS));
  end

  sample_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (accept && (state == ST_SEL)),
    .byte_valid   (accept && (state == ST_DATA)),
    .byte_data    (s_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .csum         (csum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      tbase   <= '0;
      s_ready <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      s_ready <= 1'b1;
      wr_en   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (s_data == SYNC_BYTE) begin
              state <= ST_SEL;
              busy  <= 1'b1;
            end
          end
          ST_SEL: begin
            if (sel_legal) begin
              state <= ST_DATA;
              idx   <= '0;
              tbase <= table_base(sel_wave, sel_band);
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
          ST_DATA: begin
            if (sample_valid) begin
              wr_en   <= 1'b1;
              wr_addr <= tbase + ADDR_W'(idx);
              wr_data <= sample;
              idx     <= idx + N_LUT'(1);
              if (idx == '1) state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (s_data == csum) done <= 1'b1;
            else                err  <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wavetable_writer.sv
// Scoreboard bench for wavetable_writer: frames are modelled arithmetically and expected
// writes/events are queued at stimulus time, then popped by an independent monitor.
module tb_wavetable_writer;

  localparam int L  = 1024;
  localparam int NB = 22;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  wavetable_writer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_addr[$];
  int exp_data[$];
  int exp_ev[$];   // 1 = done, 2 = err
  int smp[L];
  bit gaps = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents a write or an end-of-frame pulse.
  always @(negedge clk) begin
    if (wr_en) begin
      total++;
      if (exp_addr.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr %0d data %0h with nothing expected", wr_addr, wr_data);
      end else begin
        int a;
        int d;
        a = exp_addr.pop_front();
        d = exp_data.pop_front();
        if (int'(wr_addr) != a || int'(wr_data) != d) begin
          bad++;
          $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h", wr_addr, wr_data, a, d);
        end
      end
      check("busy_during_write", int'(busy), 1);
    end
    if (done || err) begin
      check("done_err_exclusive", int'(done && err), 0);
      total++;
      if (exp_ev.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: done %0d err %0d with nothing expected", done, err);
      end else begin
        int e;
        e = exp_ev.pop_front();
        if ((done ? 1 : 2) != e) begin
          bad++;
          $display("FAIL event: got done %0d err %0d expected code %0d", done, err, e);
        end
      end
      check("busy_low_at_end", int'(busy), 0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    if (gaps) begin
      int g;
      g = int'($urandom_range(0, 3));
      repeat (g) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    end
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < L; i++) smp[i] = int'($urandom_range(0, 24'hFFFFFF));
  endtask

  // Reference: legality and address from the layout rules, checksum as plain byte sum.
  task automatic send_frame(input logic [7:0] sel, input int csum_delta);
    int wave;
    int band;
    bit legal;
    int base;
    int sum;
    wave  = int'(sel[7:6]);
    band  = int'(sel[4:0]);
    legal = (wave == 3) ? (band == 0) : (band < NB);
    base  = (wave == 3) ? 3 * NB * L : wave * NB * L + band * L;
    sum   = 0;
    send_byte(8'hA5);
    check("busy_after_sync", int'(busy), 1);
    if (!legal) begin
      exp_ev.push_back(2);
      send_byte(sel);
    end else begin
      for (int i = 0; i < L; i++) begin
        exp_addr.push_back(base + i);
        exp_data.push_back(smp[i]);
        sum += (smp[i] >> 16) + ((smp[i] >> 8) & 255) + (smp[i] & 255);
      end
      exp_ev.push_back(csum_delta == 0 ? 1 : 2);
      send_byte(sel);
      for (int i = 0; i < L; i++) begin
        send_byte(smp[i][23:16]);
        send_byte(smp[i][15:8]);
        send_byte(smp[i][7:0]);
      end
      send_byte(8'((sum + csum_delta) & 255));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    rst_n = 1'b1;
    check("s_ready_first_cycle", int'(s_ready), 0);
    @(negedge clk);
    check("s_ready_after_reset", int'(s_ready), 1);

    // saw band 3, ramp data
    for (int i = 0; i < L; i++) smp[i] = i;
    send_frame(8'h43, 0);

    // sine
    fill_random();
    smp[0] = 24'h123456;
    send_frame(8'hC0, 0);

    // garbage, illegal selections, then a normal frame (bit 5 set, ignored)
    send_byte(8'h00);
    send_byte(8'h13);
    send_frame(8'h16, 0);
    send_frame(8'hC1, 0);
    fill_random();
    send_frame(8'h2A, 0);

    // checksum off by one
    fill_random();
    send_frame(8'h00, 1);

    // random gaps, back-to-back frames, SYNC-valued payload
    gaps = 1'b1;
    fill_random();
    smp[5] = 24'hA5A5A5;
    send_frame(8'h41, 0);
    fill_random();
    send_frame(8'h54, 0);
    gaps = 1'b0;

    // reset mid-frame: square band 5, 500 samples then reset on the 501st sample's last byte
    fill_random();
    send_byte(8'hA5);
    send_byte(8'h05);
    for (int i = 0; i < 500; i++) begin
      exp_addr.push_back(5 * L + i);
      exp_data.push_back(smp[i]);
      send_byte(smp[i][23:16]);
      send_byte(smp[i][15:8]);
      send_byte(smp[i][7:0]);
    end
    send_byte(smp[500][23:16]);
    send_byte(smp[500][15:8]);
    s_valid = 1'b1;
    s_data  = smp[500][7:0];
    rst_n   = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    check("wr_en_in_reset_1", int'(wr_en), 0);
    check("busy_in_reset_1", int'(busy), 0);
    check("s_ready_in_reset", int'(s_ready), 0);
    @(negedge clk);
    check("wr_en_in_reset_2", int'(wr_en), 0);
    rst_n = 1'b1;
    check("s_ready_first_cycle_2", int'(s_ready), 0);
    @(negedge clk);
    check("s_ready_after_reset_2", int'(s_ready), 1);

    // triangle band 21
    fill_random();
    send_frame(8'h95, 0);

    repeat (2) @(negedge clk);
    for (int k = 0; k < 20 && (exp_addr.size() != 0 || exp_ev.size() != 0); k++) @(negedge clk);
    check("writes_left", exp_addr.size(), 0);
    check("events_left", exp_ev.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
